// File: rtl/unbalanced_ram_reader.sv
// Unbalanced RAM: wide random-access write port, narrow valid/ready streaming reader.
// Each command streams len narrow sub-words from start_addr, lane 0 of each wide word first.
module unbalanced_ram_reader #(
    parameter int DATA_WIDTH_A = 64,
    parameter int ADDR_WIDTH_A = 7,
    parameter int DEINTERLEAVE = 2,
    parameter int DATA_WIDTH_B = DATA_WIDTH_A / DEINTERLEAVE,
    parameter int ADDR_WIDTH_B = ADDR_WIDTH_A + $clog2(DEINTERLEAVE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wea,
    input  logic [ADDR_WIDTH_A-1:0] addra,
    input  logic [DATA_WIDTH_A-1:0] dina,
    input  logic                    start,
    input  logic [ADDR_WIDTH_B-1:0] start_addr,
    input  logic [ADDR_WIDTH_B:0]   len,
    output logic                    busy,
    output logic [DATA_WIDTH_B-1:0] dout_tdata,
    output logic                    dout_tvalid,
    input  logic                    dout_tready,
    output logic                    dout_tlast
);
    localparam int LANE_W = $clog2(DEINTERLEAVE);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
    state_t state_q, state_d;

    logic [DATA_WIDTH_A-1:0] mem [2**ADDR_WIDTH_A];
    logic [DATA_WIDTH_A-1:0] ram_q;
    logic [ADDR_WIDTH_A-1:0] fetch_waddr;
    logic                    pf_vld;
    logic [DEINTERLEAVE-1:0][DATA_WIDTH_B-1:0] cur_word;
    logic [ADDR_WIDTH_B-1:0] out_ptr;
    logic [ADDR_WIDTH_B:0]   out_rem;
    logic                    hs, adv_word, load_cur, rd_en, cmd_ok;

    assign cmd_ok     = start && (len != '0);
    assign hs         = dout_tvalid && dout_tready;
    assign dout_tlast = dout_tvalid && (out_rem == (ADDR_WIDTH_B+1)'(1));
    assign dout_tdata = cur_word[out_ptr[LANE_W-1:0]];
    assign busy       = (state_q != IDLE);

    // Draining the last lane of a word pulls the prefetched word in the same cycle.
    assign adv_word = hs && (&out_ptr[LANE_W-1:0]) && !dout_tlast;
    assign load_cur = (state_q == STREAM) && pf_vld && (!dout_tvalid || adv_word);
    // ram_q doubles as the prefetch buffer: refill it whenever it is empty or being consumed.
    assign rd_en    = (state_q == FETCH) || ((state_q == STREAM) && (!pf_vld || load_cur));

    // Block RAM: no reset, registered read-first output held between reads.
    always_ff @(posedge clk) begin
        if (wea)
            mem[addra] <= dina;
        if (rd_en)
            ram_q <= mem[fetch_waddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_ok) state_d = FETCH;
            FETCH:   state_d = STREAM;
            STREAM:  if (hs && dout_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_waddr <= '0;
            pf_vld      <= 1'b0;
            cur_word    <= '0;
            out_ptr     <= '0;
            out_rem     <= '0;
            dout_tvalid <= 1'b0;
        end else begin
            if (state_q == IDLE && cmd_ok) begin
                out_ptr     <= start_addr;
                out_rem     <= len;
                fetch_waddr <= start_addr[ADDR_WIDTH_B-1:LANE_W];
            end else if (rd_en) begin
                fetch_waddr <= fetch_waddr + ADDR_WIDTH_A'(1);
            end

            if (state_d == IDLE)
                pf_vld <= 1'b0;
            else if (rd_en)
                pf_vld <= 1'b1;
            else if (load_cur)
                pf_vld <= 1'b0;

            if (load_cur)
                cur_word <= ram_q;

            if (hs) begin
                out_ptr <= out_ptr + ADDR_WIDTH_B'(1);
                out_rem <= out_rem - (ADDR_WIDTH_B+1)'(1);
            end

            if (hs && dout_tlast)
                dout_tvalid <= 1'b0;
            else if (load_cur)
                dout_tvalid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_unbalanced_ram_reader.sv
// Directed scoreboard bench for unbalanced_ram_reader: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_unbalanced_ram_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wea = 1'b0;
    logic [6:0]  addra = '0;
    logic [63:0] dina = '0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [8:0]  len = '0;
    logic        busy;
    logic [31:0] dout_tdata;
    logic        dout_tvalid;
    logic        dout_tready = 1'b1;
    logic        dout_tlast;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [32:0] exp_q [$];

    unbalanced_ram_reader dut (
        .clk(clk), .rst_n(rst_n), .wea(wea), .addra(addra), .dina(dina),
        .start(start), .start_addr(start_addr), .len(len), .busy(busy),
        .dout_tdata(dout_tdata), .dout_tvalid(dout_tvalid),
        .dout_tready(dout_tready), .dout_tlast(dout_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, expv);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic wr(input logic [6:0] a, input logic [63:0] d);
        wea = 1'b1; addra = a; dina = d;
        @(posedge clk); #1;
        wea = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] a, input logic [8:0] n);
        start = 1'b1; start_addr = a; len = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (i == 200) begin
            checks++; errors++;
            $display("FAIL %s timeout busy=%0b exp=0", nm, busy);
        end
        chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: handshake values at negedge equal those at the following posedge.
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev  = '0;
    logic        last_prev  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_tvalid", 64'(dout_tvalid), 64'd1);
                chk("stall_tdata", 64'(dout_tdata), 64'(data_prev));
                chk("stall_tlast", 64'(dout_tlast), 64'(last_prev));
            end
            if (dout_tvalid && dout_tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat act=%h exp=none", dout_tdata);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("beat_tdata", 64'(dout_tdata), 64'(e[31:0]));
                    chk("beat_tlast", 64'(dout_tlast), 64'(e[32]));
                end
            end
            stall_prev <= dout_tvalid && !dout_tready;
            data_prev  <= dout_tdata;
            last_prev  <= dout_tlast;
        end
    end

    task automatic push_aligned();
        expect_beat(32'h33334444, 1'b0);
        expect_beat(32'h11112222, 1'b0);
        expect_beat(32'h77778888, 1'b0);
        expect_beat(32'h55556666, 1'b1);
    endtask

    initial begin
        logic [6:0] bp_pat;
        int b0;
        bp_pat = 7'b1101001; // applied LSB first: 1,0,0,1,0,1,1

        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalid", 64'(dout_tvalid), 64'd0);
        chk("rst_tlast", 64'(dout_tlast), 64'd0);
        chk("rst_tdata", 64'(dout_tdata), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        wr(7'd0,   64'h1111_2222_3333_4444);
        wr(7'd1,   64'h5555_6666_7777_8888);
        wr(7'd127, 64'hAAAA_AAAA_BBBB_BBBB);

        // Aligned burst with exact latency and contiguity
        push_aligned();
        cmd(8'd0, 9'd4);
        chk("aln_busy_T", 64'(busy), 64'd1);
        chk("aln_tvalid_T", 64'(dout_tvalid), 64'd0);
        @(posedge clk); #1;
        chk("aln_tvalid_T1", 64'(dout_tvalid), 64'd0);
        @(posedge clk); #1;
        chk("aln_tvalid_T2", 64'(dout_tvalid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("aln_contig", 64'(dout_tvalid), 64'd1);
        end
        @(posedge clk); #1;
        chk("aln_busy_end", 64'(busy), 64'd0);
        chk("aln_tvalid_end", 64'(dout_tvalid), 64'd0);
        wait_idle("aligned");

        // Unaligned start
        expect_beat(32'h11112222, 1'b0);
        expect_beat(32'h77778888, 1'b1);
        cmd(8'd1, 9'd2);
        wait_idle("unaligned");

        // Backpressure
        push_aligned();
        cmd(8'd0, 9'd4);
        for (int i = 0; i < 7; i++) begin
            dout_tready = bp_pat[i];
            @(posedge clk); #1;
        end
        dout_tready = 1'b1;
        wait_idle("backpressure");

        // Wrap from narrow 255 to 0
        expect_beat(32'hAAAAAAAA, 1'b0);
        expect_beat(32'h33334444, 1'b1);
        cmd(8'd255, 9'd2);
        wait_idle("wrap");

        // len=0 ignored
        cmd(8'd0, 9'd0);
        for (int i = 0; i < 4; i++) begin
            chk("len0_busy", 64'(busy), 64'd0);
            chk("len0_tvalid", 64'(dout_tvalid), 64'd0);
            @(posedge clk); #1;
        end

        // start during burst ignored
        push_aligned();
        b0 = beats;
        cmd(8'd0, 9'd4);
        @(posedge clk); #1;
        cmd(8'd2, 9'd2);
        wait_idle("start_busy");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("start_busy_beats", 64'(beats - b0), 64'd4);
        chk("start_busy_idle", 64'(busy), 64'd0);

        // Reset mid-stream
        push_aligned();
        b0 = beats;
        cmd(8'd0, 9'd4);
        for (int i = 0; i < 50; i++) begin
            if (beats >= b0 + 2) break;
            @(posedge clk); #1;
        end
        chk("mid_two_beats", 64'(beats - b0), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(dout_tvalid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_tlast", 64'(dout_tlast), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("post_rst_silent", 64'(beats - b0), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        push_aligned();
        cmd(8'd0, 9'd4);
        wait_idle("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unbalanced_ram_reader.md
# unbalanced_ram_reader

Single-clock unbalanced RAM with a wide random-access write port and a narrow streaming read engine. A producer writes DATA_WIDTH_A-bit words. A command (start address, length in narrow words) then streams the contents out as DATA_WIDTH_B-bit sub-words on a valid/ready interface, lane 0 (LSB) first. It sits between wide datapaths (accumulators, FFT bins) and narrow consumers (AXI-Stream/AXI-Lite bridges, UART dumpers). It is the read-side counterpart of the narrow-write/wide-read unbalanced RAM.

## Interface
- DATA_WIDTH_A, 64, wide word width; must be divisible by DEINTERLEAVE
- ADDR_WIDTH_A, 7, wide address width; depth 2**ADDR_WIDTH_A
- DEINTERLEAVE, 2, sub-words per wide word; power of two, ≥2
- DATA_WIDTH_B, DATA_WIDTH_A/DEINTERLEAVE, narrow width (derived)
- ADDR_WIDTH_B, ADDR_WIDTH_A+$clog2(DEINTERLEAVE), narrow address width (derived)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wea  in  1  write strobe for the wide port
- addra  in  ADDR_WIDTH_A  wide write address
- dina  in  DATA_WIDTH_A  wide write data
- start  in  1  command strobe, accepted only when idle
- start_addr  in  ADDR_WIDTH_B  first narrow address
- len  in  ADDR_WIDTH_B+1  number of narrow words, 1..2**ADDR_WIDTH_B
- busy  out  1  command in progress
- dout_tdata  out  DATA_WIDTH_B  narrow data
- dout_tvalid  out  1  data valid
- dout_tready  in  1  consumer ready
- dout_tlast  out  1  final beat of command

## Operation
- Memory is inferred block RAM with registered read and read-first semantics. It is not cleared by reset; contents survive reset.
- Write: wea=1 stores dina at addra on the edge. Writes are legal at any time, including while streaming.
- Narrow address p maps to wide word p[ADDR_WIDTH_B-1:$clog2(DEINTERLEAVE)] and lane p[$clog2(DEINTERLEAVE)-1:0]. Lane k is bits [k*DATA_WIDTH_B +: DATA_WIDTH_B].
- FSM states:
  - IDLE: start=1 with len≠0 latches start_addr/len and goes to FETCH. start with len=0 is ignored.
  - FETCH: issues the read of the first wide word, then goes to STREAM.
  - STREAM: emits beats. Prefetches the next wide word while the current one drains. Returns to IDLE on the handshake of the beat with tlast.
- A beat transfers when tvalid&tready. The pointer then increments mod 2**ADDR_WIDTH_B (wraps from max to 0), and the remaining count decrements.
- Unaligned start: the first beat is the lane selected by start_addr; subsequent lanes follow in order.
- tlast=1 exactly when the remaining count is 1.
- start while busy=1 is ignored; no queuing.
- Collision: a write to a wide word already fetched or prefetched is not reflected in the current stream. A same-cycle write and read of the same address returns the old data.

## Timing
- Reset values: busy=0, dout_tvalid=0, dout_tlast=0, dout_tdata=0. Reset is asynchronous and takes effect immediately.
- Reset mid-command aborts it: the FSM returns to IDLE, the prefetch is discarded, and nothing is emitted after release.
- start sampled at edge T: busy=1 after T; first tvalid=1 after edge T+2.
- With tready held high, the engine sends one beat per cycle with no bubbles, including across wide-word and wrap boundaries.
- While tvalid=1 and tready=0, tdata and tlast hold stable and tvalid stays high.
- tvalid never depends combinationally on tready.
- busy and tvalid fall after the edge that completes the tlast handshake. A new start is accepted in the next cycle.
- Write-to-read: data written at edge W is visible to a command started at edge ≥W.

## Test plan
- Aligned burst: write wide[0]=0x1111_2222_3333_4444 and wide[1]=0x5555_6666_7777_8888, then start addr 0, len 4, tready=1 -> beats 0x33334444, 0x11112222, 0x77778888, 0x55556666. tlast on the 4th beat only; first tvalid at T+2; contiguous; busy low after the 4th beat.
- Unaligned: same memory, start_addr 1, len 2 -> 0x11112222, 0x77778888 (tlast on the second).
- Backpressure: aligned burst with tready pattern 1,0,0,1,0,1,1 -> identical data order. tdata is stable during stalls, with no drops or duplicates.
- Wrap: wide[127]=0xAAAA_AAAA_BBBB_BBBB and wide[0] as above, start_addr 255, len 2 -> 0xAAAAAAAA, then 0x33334444 with tlast.
- Ignored commands: start with len=0 -> busy stays 0 and no tvalid. start pulsed during a len-4 burst -> exactly 4 beats emitted and no second burst.
- Reset mid-stream: rst_n low after 2 beats of the aligned burst -> tvalid, busy and tlast drop to 0 immediately. After release, a fresh aligned burst returns the original 4 values.
